// File: rtl/tinyrv1_fetch_unit.sv
// TinyRV1 instruction fetch stage: credit-limited val/rdy requests to instruction memory,
// an in-flight PC FIFO, and a small {pc, inst} queue toward decode with redirect squashing.
module tinyrv1_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemreq_val,
   input  logic        imemreq_rdy,
   output logic [31:0] imemreq_addr,
   input  logic        imemresp_val,
   input  logic [31:0] imemresp_data,
   output logic        out_val,
   input  logic        out_rdy,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_val,
   input  logic [31:0] redirect_target
);

   localparam int AW    = $clog2(QDEPTH);
   localparam int CW    = AW + 1;
   localparam int SUM_W = CW + 1;

   // control state
   logic [31:0]   r_pc_f;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_squash_cnt;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_pf_wr;
   logic [AW-1:0] r_pf_rd;
   logic [AW-1:0] r_q_wr;
   logic [AW-1:0] r_q_rd;

   // storage
   logic [31:0]   r_pf_mem [QDEPTH];
   logic [31:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_inst [QDEPTH];

   logic [SUM_W-1:0] w_occupancy;
   logic             w_credit;
   logic             w_req_val;
   logic             w_issue;
   logic             w_resp;
   logic             w_squashing;
   logic             w_push;
   logic             w_out_val;
   logic             w_pop;
   logic [31:0]      w_redirect_pc;

   // Every request ever issued either sits in flight or occupies a queue slot,
   // so bounding their sum by QDEPTH makes queue overflow impossible.
   assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
   assign w_credit    = w_occupancy < SUM_W'(QDEPTH);
   assign w_req_val   = rst_n && !redirect_val && w_credit;
   assign w_issue     = w_req_val && imemreq_rdy;

   // A response with nothing outstanding cannot belong to us and is dropped.
   assign w_resp      = rst_n && imemresp_val && (r_inflight != '0);
   assign w_squashing = (r_squash_cnt != '0);
   assign w_push      = w_resp && !w_squashing && !redirect_val;

   assign w_out_val   = rst_n && (r_count != '0);
   assign w_pop       = w_out_val && out_rdy && !redirect_val;

   // Low target bits are masked to zero; they are still referenced so every bit is consumed.
   assign w_redirect_pc = {redirect_target[31:2], redirect_target[1:0] & 2'b00};

   assign imemreq_val  = w_req_val;
   assign imemreq_addr = r_pc_f;
   assign out_val      = w_out_val;
   assign out_pc       = w_out_val ? r_q_pc[r_q_rd]   : 32'h0;
   assign out_inst     = w_out_val ? r_q_inst[r_q_rd] : 32'h0;

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // register in this block sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc_f       <= {RESET_PC[31:2], 2'b00};
         r_inflight   <= '0;
         r_squash_cnt <= '0;
         r_count      <= '0;
         r_pf_wr      <= '0;
         r_pf_rd      <= '0;
         r_q_wr       <= '0;
         r_q_rd       <= '0;
      end else begin
         if (redirect_val) begin
            r_pc_f <= w_redirect_pc;
         end else if (w_issue) begin
            r_pc_f <= r_pc_f + 32'd4;
         end

         r_inflight <= r_inflight + CW'(w_issue) - CW'(w_resp);
         if (w_issue) begin
            r_pf_wr <= r_pf_wr + AW'(1);
         end
         if (w_resp) begin
            r_pf_rd <= r_pf_rd + AW'(1);
         end

         // Everything still outstanding after this cycle's response belongs to the old path.
         if (redirect_val) begin
            r_squash_cnt <= r_inflight - CW'(w_resp);
         end else if (w_resp && w_squashing) begin
            r_squash_cnt <= r_squash_cnt - CW'(1);
         end

         if (redirect_val) begin
            r_count <= '0;
            r_q_wr  <= '0;
            r_q_rd  <= '0;
         end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
               r_q_wr <= r_q_wr + AW'(1);
            end
            if (w_pop) begin
               r_q_rd <= r_q_rd + AW'(1);
            end
         end
      end
   end

   // NOTE: the storage arrays are deliberately not reset; the counters and pointers
   // above define which entries are meaningful, and the outputs are forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_pf_mem[r_pf_wr] <= r_pc_f;
      end
      if (w_push) begin
         r_q_pc[r_q_wr]   <= r_pf_mem[r_pf_rd];
         r_q_inst[r_q_wr] <= imemresp_data;
      end
   end

endmodule
